// File: rtl/nes_cpu_bus_master_if.sv
// Host request/response port and cartridge CPU bus, bundled.
// The master modport is the bus initiator's view.
interface nes_cpu_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        m2;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_data_out;
    logic        cpu_data_oe;
    logic [7:0]  cpu_data_in;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  cpu_data_in,
        output req_ready, rsp_valid, rsp_rdata,
        output m2, cpu_addr, cpu_rw, cpu_data_out, cpu_data_oe
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output cpu_data_in,
        input  req_ready, rsp_valid, rsp_rdata,
        input  m2, cpu_addr, cpu_rw, cpu_data_out, cpu_data_oe
    );
endinterface

// File: rtl/nes_cpu_bus_master.sv
// 6502-style M2 bus cycle generator for the cartridge CPU bus.
// Runs host read/write requests, filling idle time with dummy reads.
module nes_cpu_bus_master #(
    parameter int          LOW_CLKS  = 6,
    parameter int          HIGH_CLKS = 10,
    parameter logic [15:0] IDLE_ADDR = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    nes_cpu_bus_master_if.master  bus
);
    localparam int MAXC = (LOW_CLKS > HIGH_CLKS) ? LOW_CLKS : HIGH_CLKS;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] LOW_LAST  = CW'(LOW_CLKS - 1);
    localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_CLKS - 1);

    typedef enum logic [1:0] {
        STOP,
        LOW,
        HIGH
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          decide;
    logic          accept;

    logic          m2_q;
    logic [15:0]   addr_q;
    logic          rw_q;
    logic [7:0]    dout_q;
    logic          oe_q;
    logic          rsp_v_q;
    logic [7:0]    rdata_q;

    // Descriptor of the bus cycle currently in flight.
    logic [15:0]   cyc_addr;
    logic          cyc_write;
    logic [7:0]    cyc_wdata;
    logic          cyc_host;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        decide  = 1'b0;
        unique case (state)
            STOP: begin
                if (run) begin
                    decide  = 1'b1;
                    state_d = LOW;
                    cnt_d   = '0;
                end
            end
            LOW: begin
                if (cnt == LOW_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            HIGH: begin
                if (cnt == HIGH_LAST) begin
                    decide  = 1'b1;
                    cnt_d   = '0;
                    state_d = (bus.req_valid || run) ? LOW : STOP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = STOP;
        endcase
        accept = decide & bus.req_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STOP;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m2_q      <= 1'b0;
            addr_q    <= IDLE_ADDR;
            rw_q      <= 1'b1;
            dout_q    <= 8'h00;
            oe_q      <= 1'b0;
            rsp_v_q   <= 1'b0;
            rdata_q   <= 8'h00;
            cyc_addr  <= IDLE_ADDR;
            cyc_write <= 1'b0;
            cyc_wdata <= 8'h00;
            cyc_host  <= 1'b0;
        end else begin
            rsp_v_q <= 1'b0;
            if (decide) begin
                cyc_host  <= accept;
                cyc_write <= accept & bus.req_write;
                cyc_addr  <= accept ? bus.req_addr : IDLE_ADDR;
                if (accept) begin
                    cyc_wdata <= bus.req_wdata;
                end
            end
            unique case (state)
                STOP: oe_q <= 1'b0;
                LOW: begin
                    // Old address/data stay put for one clk past M2 fall.
                    if (cnt == '0) begin
                        addr_q <= cyc_addr;
                        rw_q   <= ~cyc_write;
                        oe_q   <= 1'b0;
                    end
                    if (cnt == LOW_LAST) begin
                        m2_q <= 1'b1;
                        if (cyc_write) begin
                            dout_q <= cyc_wdata;
                            oe_q   <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (cnt == HIGH_LAST) begin
                        m2_q    <= 1'b0;
                        rsp_v_q <= cyc_host;
                        if (cyc_host && !cyc_write) begin
                            rdata_q <= bus.cpu_data_in;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = decide;
    assign bus.rsp_valid    = rsp_v_q;
    assign bus.rsp_rdata    = rdata_q;
    assign bus.m2           = m2_q;
    assign bus.cpu_addr     = addr_q;
    assign bus.cpu_rw       = rw_q;
    assign bus.cpu_data_out = dout_q;
    assign bus.cpu_data_oe  = oe_q;
endmodule

// File: tb/tb_nes_cpu_bus_master.sv
// Randomized bench for nes_cpu_bus_master against a bus-cycle model.
// The model tracks cycle descriptors and position within the M2 period.
module tb_nes_cpu_bus_master;
    localparam int L = 6;
    localparam int H = 10;
    localparam int P = L + H;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;

    nes_cpu_bus_master_if bus ();

    nes_cpu_bus_master #(
        .LOW_CLKS  (L),
        .HIGH_CLKS (H),
        .IDLE_ADDR (16'hFFFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  data;
        logic        host;
    } cyc_t;

    localparam cyc_t IDLE = '{16'hFFFF, 1'b0, 8'h00, 1'b0};

    cyc_t       cur, last;
    bit         known, stopped, hold_live, stop_first;
    int         pos;
    logic [7:0] dbus, rdata;

    bit          pend;
    logic [15:0] p_addr;
    logic        p_wr;
    logic [7:0]  p_data;
    bit          force_din;
    logic [7:0]  din_val;
    int          rsp_seen, oe_seen;

    function automatic bit m_ready();
        return stopped ? run : (pos == P - 1);
    endfunction

    task automatic m_edge(output bit acc);
        acc = 0;
        if (reset) begin
            known = 1; stopped = 1; stop_first = 0; hold_live = 0;
            pos = 0; last = IDLE; cur = IDLE; dbus = 0; rdata = 0;
            return;
        end
        if (!known) return;
        if (!m_ready()) begin
            if (stopped) stop_first = 0;
            else begin
                pos++;
                if (pos == L && cur.wr) dbus = cur.data;
            end
            return;
        end
        hold_live = !stopped;
        if (!stopped) begin
            if (cur.host && !cur.wr) rdata = bus.cpu_data_in;
            last = cur;
        end
        stop_first = 0;
        if (pend) begin
            acc = 1;
            cur = '{p_addr, p_wr, p_data, 1'b1};
        end else if (run) begin
            cur = IDLE;
        end else begin
            stopped = 1;
            stop_first = 1;
            return;
        end
        stopped = 0;
        pos = 0;
    endtask

    task automatic check_outs();
        logic        e_m2, e_rw, e_oe, e_rsp;
        logic [15:0] e_addr;
        if (stopped || pos == 0) begin
            bit live = stopped ? stop_first : hold_live;
            e_m2 = 0; e_addr = last.addr; e_rw = !last.wr;
            e_oe = live && last.wr; e_rsp = live && last.host;
        end else begin
            e_m2 = (pos >= L); e_addr = cur.addr; e_rw = !cur.wr;
            e_oe = (pos >= L) && cur.wr; e_rsp = 0;
        end
        check("m2", bus.m2, e_m2);
        check("cpu_addr", bus.cpu_addr, e_addr);
        check("cpu_rw", bus.cpu_rw, e_rw);
        check("cpu_data_oe", bus.cpu_data_oe, e_oe);
        check("cpu_data_out", bus.cpu_data_out, dbus);
        check("rsp_valid", bus.rsp_valid, e_rsp);
        check("rsp_rdata", bus.rsp_rdata, rdata);
    endtask

    task automatic drive();
        bus.req_valid   = pend;
        bus.req_write   = p_wr;
        bus.req_addr    = p_addr;
        bus.req_wdata   = p_data;
        bus.cpu_data_in = force_din ? din_val : 8'($urandom);
    endtask

    task automatic tick();
        bit acc;
        @(negedge clk);
        if (known) check("req_ready", bus.req_ready, m_ready());
        @(posedge clk);
        m_edge(acc);
        #1;
        if (known) check_outs();
        if (bus.rsp_valid) rsp_seen++;
        if (bus.cpu_data_oe) oe_seen++;
        if (acc) begin
            pend = 0;
            p_addr = 16'($urandom);
        end
        drive();
    endtask

    task automatic post(input logic [15:0] a, input logic w,
                        input logic [7:0] d);
        p_addr = a; p_wr = w; p_data = d; pend = 1;
        drive();
    endtask

    task automatic wait_accept(input string tag);
        for (int i = 0; i < 4 * P && pend; i++) tick();
        check(tag, pend, 1'b0);
    endtask

    task automatic wait_pos(input string tag, input int want);
        int i = 0;
        while (i < 4 * P && !(!stopped && pos == want)) begin
            tick();
            i++;
        end
        check(tag, pos, want);
    endtask

    initial begin
        pend = 0; p_addr = 0; p_wr = 0; p_data = 0;
        force_din = 0; din_val = 0;
        drive();
        reset = 1; run = 0;
        repeat (3) tick();
        reset = 0;
        repeat (4) tick();

        // free-running dummy reads
        run = 1;
        rsp_seen = 0; oe_seen = 0;
        repeat (3 * P) tick();
        check("idle_rsp", rsp_seen, 0);
        check("idle_oe", oe_seen, 0);

        // write 1F to 8000
        rsp_seen = 0; oe_seen = 0;
        post(16'h8000, 1'b1, 8'h1F);
        wait_accept("wr_accept");
        repeat (2 * P) tick();
        check("wr_oe_clks", oe_seen, H + 1);
        check("wr_rsp", rsp_seen, 1);

        // read at C000 returning A5
        force_din = 1; din_val = 8'hA5;
        rsp_seen = 0;
        post(16'hC000, 1'b0, 8'h00);
        wait_accept("rd_accept");
        repeat (2 * P) tick();
        check("rd_rsp", rsp_seen, 1);
        check("rd_data", bus.rsp_rdata, 8'hA5);
        force_din = 0;

        // three back-to-back requests
        rsp_seen = 0;
        for (int k = 0; k < 3; k++) begin
            post(16'h6000 + 16'(k), k[0], 8'(k + 8'h40));
            wait_accept("b2b_accept");
        end
        repeat (2 * P) tick();
        check("b2b_rsp", rsp_seen, 3);

        // run drops during HIGH, then resumes
        wait_pos("run_pos", L + 2);
        run = 0;
        repeat (2 * P) tick();
        check("stop_m2", bus.m2, 1'b0);
        run = 1;
        repeat (P) tick();

        // reset at HIGH counter 4 of a write
        post(16'h8123, 1'b1, 8'h77);
        wait_accept("rst_accept");
        wait_pos("rst_pos", L + 4);
        rsp_seen = 0;
        reset = 1;
        tick();
        reset = 0;
        check("rst_oe", bus.cpu_data_oe, 1'b0);
        check("rst_addr", bus.cpu_addr, 16'hFFFF);
        repeat (P) tick();
        check("rst_no_rsp", rsp_seen, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!pend && $urandom_range(0, 3) == 0)
                post(16'($urandom), 1'($urandom), 8'($urandom));
            if ($urandom_range(0, 39) == 0) run = ~run;
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/nes_cpu_bus_master.md
Name: nes_cpu_bus_master

Overview:
- Initiator side of the cartridge CPU bus: generates 6502-style M2 bus cycles (m2, cpu_addr, cpu_rw, data) that mapper logic responds to.
- Host logic (loader, debugger, simulation harness) issues single read/write requests over a valid/ready port.
- While idle and enabled, it emits free-running dummy read cycles so M2-clocked mapper logic keeps counting.
- Sits between the host-side control logic and the mapper bus interface.

Parameters:
- LOW_CLKS, 6, clk cycles per M2-low phase (phi1); must be >= 2.
- HIGH_CLKS, 10, clk cycles per M2-high phase (phi2); must be >= 2.
- IDLE_ADDR, 16'hFFFF, address driven by dummy read cycles and in STOP.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  1 = generate M2 cycles continuously; 0 = stop after the current cycle.
- req_valid  input  1  host request valid.
- req_ready  output  1  request accepted this clk when req_valid=1.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  16  CPU address.
- req_wdata  input  8  write data.
- rsp_valid  output  1  one-clk completion pulse, for reads and writes.
- rsp_rdata  output  8  read data; valid when rsp_valid=1 after a read.
- m2  output  1  M2 clock to the mapper.
- cpu_addr  output  16  CPU address bus.
- cpu_rw  output  1  1 = read, 0 = write.
- cpu_data_out  output  8  write data bus.
- cpu_data_oe  output  1  write data drive enable.
- cpu_data_in  input  8  read data from the mapper/PRG.

Behaviour:
- Reset values: state=STOP, m2=0, cpu_addr=IDLE_ADDR, cpu_rw=1, cpu_data_out=0, cpu_data_oe=0, req_ready=0, rsp_valid=0, rsp_rdata=0, phase counter=0.
- Reset asserted mid-cycle: all outputs return to reset values on the next edge. The in-flight request is dropped and no rsp_valid is issued.
- States:
  - STOP: m2=0, address held.
  - LOW: m2=0, counter 0..LOW_CLKS-1.
  - HIGH: m2=1, counter 0..HIGH_CLKS-1.
- One bus cycle = LOW_CLKS + HIGH_CLKS clks.
- Decision point: STOP with run=1, or the last HIGH clk (counter=HIGH_CLKS-1).
  - req_ready=1 (combinational) only at a decision point. Elsewhere req_ready=0.
  - If req_valid=1 at the decision point, the request is latched (addr, write, wdata) and the next cycle is a host cycle.
  - Else if run=1, the next cycle is a dummy read at IDLE_ADDR.
  - Else the block enters STOP.
- STOP with run=0: req_ready=0; requests wait.
- Transitions: STOP->LOW at the decision point with run=1 or an accepted request; LOW->HIGH after LOW_CLKS clks; HIGH->LOW or STOP after HIGH_CLKS clks.
- Hold time:
  - At LOW counter 0 (the first clk after m2 falls), the previous cycle's cpu_addr, cpu_rw, cpu_data_out and cpu_data_oe are held unchanged.
  - At LOW counter 1, the new cycle's cpu_addr and cpu_rw are applied, and cpu_data_oe=0.
  - This guarantees address/data are stable across the M2 falling edge where mappers latch.
- Writes: cpu_data_out=wdata, cpu_data_oe=1 for all HIGH clks plus LOW counter 0 of the following cycle.
- Reads: rsp_rdata<=cpu_data_in on the last HIGH clk edge, i.e. the same edge on which m2 goes 0.
- rsp_valid:
  - Pulses 1 clk at LOW counter 0 following any host cycle, read or write. Never asserted for dummy cycles.
  - After a write, rsp_rdata keeps its previous value.
- run deasserted mid-cycle: the current cycle completes normally, then the block enters STOP. A request accepted at that decision point still executes.
- A request presented mid-cycle waits. Back-to-back requests execute with no dummy cycle between them.

Test Plan:
- Reset, run=1, no requests -> m2 period 16 clks (6 low, 10 high), cpu_addr=16'hFFFF, cpu_rw=1, rsp_valid never 1, cpu_data_oe=0.
- Write 8'h1F to 16'h8000 -> at LOW counter 1 cpu_addr=16'h8000 and cpu_rw=0. cpu_data_out=8'h1F with oe=1 for 11 clks (HIGH + 1). rsp_valid pulses once at the clk after m2 falls.
- cpu_data_in=8'hA5 during the HIGH phase of a read at 16'hC000 -> rsp_valid=1, rsp_rdata=8'hA5 at LOW counter 0 of the next cycle.
- Three back-to-back requests held valid -> each is accepted at consecutive decision points, exactly 3 rsp_valid pulses 16 clks apart, no IDLE_ADDR cycles in between.
- run drops during a HIGH phase with no request -> the cycle finishes, m2 stays 0, req_ready=0. run=1 again -> LOW resumes next clk.
- reset asserted at HIGH counter 4 of a write -> next clk m2=0, cpu_data_oe=0, cpu_addr=16'hFFFF, no rsp_valid.
